// File: rtl/sync_to_async_bridge_if.sv
// Handshake bundle for sync_to_async_bridge.
// Synchronous side: sync_valid / sync_ready / sync_d (ready/valid push port).
// Asynchronous side: async_req / async_ack / async_d (bundled-data req/ack port).
// Modports:
//   master - the bridge: consumes the sync port, drives the async request.
//   slave  - the environment: producer on the sync side, responder on the async side.
interface sync_to_async_bridge_if #(
  parameter int unsigned DATA_WIDTH = 8
) ();

  logic                  sync_valid;
  logic                  sync_ready;
  logic [DATA_WIDTH-1:0] sync_d;
  logic                  async_req;
  logic                  async_ack;
  logic [DATA_WIDTH-1:0] async_d;

  modport master (
    input  sync_valid,
    input  sync_d,
    input  async_ack,
    output sync_ready,
    output async_req,
    output async_d
  );

  modport slave (
    output sync_valid,
    output sync_d,
    output async_ack,
    input  sync_ready,
    input  async_req,
    input  async_d
  );

endinterface

// File: rtl/sync_to_async_bridge.sv
// Sync-to-async bridge: buffers words from a clocked ready/valid port in a small FIFO and
// drains them one at a time onto a bundled-data req/ack port, using either 4-phase
// (return-to-zero) or 2-phase (transition) signalling.
// Ports:
//   clock_i        - single clock, all state on the rising edge
//   reset_ni       - asynchronous active-low reset
//   bus_io         - handshake bundle (master modport): sync push port + async req/ack port
//   busy_o         - FSM not idle or FIFO not empty
//   fifo_level_o   - current FIFO occupancy
//   timeout_err_o  - sticky flag: ack wait reached TIMEOUT_CYCLES
// The interface instance must use the same DATA_WIDTH as this module.
module sync_to_async_bridge #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned DEPTH          = 4,
  parameter int unsigned SYNC_STAGE     = 2,
  parameter int unsigned PROTOCOL       = 0,
  parameter int unsigned TIMEOUT_CYCLES = 0,
  localparam int unsigned LevelW        = $clog2(DEPTH + 1)
) (
  input  logic                   clock_i,
  input  logic                   reset_ni,
  sync_to_async_bridge_if.master bus_io,
  output logic                   busy_o,
  output logic [LevelW-1:0]      fifo_level_o,
  output logic                   timeout_err_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CntW-1:0]   TmoMax    = CntW'(TIMEOUT_CYCLES);
  localparam logic [LevelW-1:0] LevelFull = LevelW'(DEPTH);
  localparam bit                TwoPhase  = (PROTOCOL == 1);
  localparam bit                TmoEn     = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {StIdle, StSetup, StReq, StRelease} state_e;

  // ---------------------------------------------------------------------------
  // async_ack synchroniser
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGE-1:0] ack_sync_q;
  logic                  ack_s;

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      ack_sync_q <= '0;
    end else begin
      ack_sync_q[0] <= bus_io.async_ack;
      for (int i = 1; i < int'(SYNC_STAGE); i++) begin
        ack_sync_q[i] <= ack_sync_q[i-1];
      end
    end
  end

  assign ack_s = ack_sync_q[SYNC_STAGE-1];

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]       wptr_q, wptr_d;
  logic [PtrW-1:0]       rptr_q, rptr_d;
  logic [LevelW-1:0]     count_q, count_d;
  logic                  ready;
  logic                  push;
  logic                  pop;
  state_e                state_q;

  // Gated by reset so the producer never sees ready while the bridge is held in reset.
  assign ready = reset_ni & (count_q != LevelFull);
  assign push  = bus_io.sync_valid & ready;
  // The head is popped straight into the output register as the FSM leaves IDLE.
  assign pop   = (state_q == StIdle) && (count_q != '0);

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push) wptr_d = wptr_q + 1'b1;
    if (pop)  rptr_d = rptr_q + 1'b1;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: occupancy is tracked by count_q alone.
  always_ff @(posedge clock_i) begin
    if (push) mem_q[wptr_q] <= bus_io.sync_d;
  end

  // ---------------------------------------------------------------------------
  // Handshake FSM with registered outputs
  // ---------------------------------------------------------------------------
  logic                  req_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [CntW-1:0]       tmo_cnt_q;
  logic                  tmo_err_q;
  logic                  req_done;
  logic                  tmo_step;
  logic [CntW-1:0]       tmo_inc;

  // 4-phase waits for ack high; 2-phase waits for ack to match the new req level.
  assign req_done = TwoPhase ? (ack_s == req_q) : ack_s;
  // Counter saturates at TmoMax; disabled entirely when TIMEOUT_CYCLES is 0.
  assign tmo_step = TmoEn && (tmo_cnt_q != TmoMax);
  assign tmo_inc  = tmo_cnt_q + 1'b1;

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q   <= StIdle;
      req_q     <= 1'b0;
      data_q    <= '0;
      tmo_cnt_q <= '0;
      tmo_err_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (count_q != '0) begin
            data_q  <= mem_q[rptr_q];
            state_q <= StSetup;
          end
        end
        // One cycle of data setup ahead of the request edge.
        StSetup: begin
          req_q     <= TwoPhase ? ~req_q : 1'b1;
          tmo_cnt_q <= '0;
          state_q   <= StReq;
        end
        StReq: begin
          if (req_done) begin
            if (TwoPhase) begin
              state_q <= StIdle;
            end else begin
              req_q     <= 1'b0;
              tmo_cnt_q <= '0;
              state_q   <= StRelease;
            end
          end else if (tmo_step) begin
            tmo_cnt_q <= tmo_inc;
            if (tmo_inc == TmoMax) tmo_err_q <= 1'b1;
          end
        end
        StRelease: begin
          if (!ack_s) begin
            state_q <= StIdle;
          end else if (tmo_step) begin
            tmo_cnt_q <= tmo_inc;
            if (tmo_inc == TmoMax) tmo_err_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus_io.sync_ready = ready;
  assign bus_io.async_req  = req_q;
  assign bus_io.async_d    = data_q;
  assign busy_o            = (state_q != StIdle) || (count_q != '0);
  assign fifo_level_o      = count_q;
  assign timeout_err_o     = tmo_err_q;

endmodule

// File: tb/tb_sync_to_async_bridge.sv
// Directed bench for sync_to_async_bridge. Four instances share clock and reset:
//   [0] 4-phase, SYNC_STAGE=2, TIMEOUT_CYCLES=8
//   [1] 2-phase, SYNC_STAGE=2
//   [2] 4-phase, SYNC_STAGE=1
//   [3] 4-phase, SYNC_STAGE=3
// Each async port has a responder that copies req onto ack after a per-instance delay.
module tb_sync_to_async_bridge;

  localparam int unsigned ProtoTab [4] = '{0, 1, 0, 0};
  localparam int unsigned SsTab    [4] = '{2, 2, 1, 3};
  localparam int unsigned TmoTab   [4] = '{8, 0, 0, 0};

  logic clk;
  logic rst_n;

  logic [3:0]       vld;
  logic [3:0][7:0]  dat;
  logic [3:0]       ack_r;
  logic [3:0]       rdy_w;
  logic [3:0]       req_w;
  logic [3:0][7:0]  ad_w;
  logic [3:0]       busy_w;
  logic [3:0][2:0]  lvl_w;
  logic [3:0]       tmo_w;

  bit   [3:0] ack_en = '0;
  int         ack_dly [4] = '{3, 2, 3, 3};

  logic [7:0] log_a [$];
  logic [8:0] log_b [$];

  int n_checks = 0;
  int n_errors = 0;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    sync_to_async_bridge_if #(.DATA_WIDTH(8)) bus ();

    assign bus.sync_valid = vld[g];
    assign bus.sync_d     = dat[g];
    assign bus.async_ack  = ack_r[g];
    assign rdy_w[g]       = bus.sync_ready;
    assign req_w[g]       = bus.async_req;
    assign ad_w[g]        = bus.async_d;

    sync_to_async_bridge #(
      .DATA_WIDTH    (8),
      .DEPTH         (4),
      .SYNC_STAGE    (SsTab[g]),
      .PROTOCOL      (ProtoTab[g]),
      .TIMEOUT_CYCLES(TmoTab[g])
    ) u_dut (
      .clock_i      (clk),
      .reset_ni     (rst_n),
      .bus_io       (bus),
      .busy_o       (busy_w[g]),
      .fifo_level_o (lvl_w[g]),
      .timeout_err_o(tmo_w[g])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ack follows req once the mismatch has been seen on ack_dly consecutive samples
  initial begin
    int cnt [4];
    for (int k = 0; k < 4; k++) begin
      ack_r[k] = 1'b0;
      cnt[k]   = 0;
    end
    forever begin
      @(posedge clk); #1;
      for (int k = 0; k < 4; k++) begin
        if (!ack_en[k] || (req_w[k] == ack_r[k])) begin
          cnt[k] = 0;
        end else begin
          cnt[k]++;
          if (cnt[k] >= ack_dly[k]) begin
            ack_r[k] = req_w[k];
            cnt[k]   = 0;
          end
        end
      end
    end
  end

  // Log data on every request edge of instances 0 and 1
  initial begin
    logic [3:0] prev;
    prev = '0;
    forever begin
      @(posedge clk); #1;
      if (req_w[0] && !prev[0]) log_a.push_back(ad_w[0]);
      if (req_w[1] != prev[1])  log_b.push_back({req_w[1], ad_w[1]});
      prev = req_w;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Holds valid until accepted; returns 1ns after the accepting edge.
  task automatic push(input int k, input logic [7:0] d);
    logic ok;
    logic done;
    done   = 1'b0;
    vld[k] = 1'b1;
    dat[k] = d;
    for (int i = 0; i < 100 && !done; i++) begin
      ok = rdy_w[k];
      @(posedge clk); #1;
      done = ok;
    end
    vld[k] = 1'b0;
    check_eq("push_accept", {31'b0, done}, 32'd1);
  endtask

  task automatic wait_idle(input int k, input int budget);
    for (int i = 0; i < budget && busy_w[k]; i++) tick(1);
    check_eq("wait_idle", {31'b0, busy_w[k]}, 32'd0);
  endtask

  initial begin
    int rise [2];
    int fall [2];
    logic [8:0] exp_b [3];

    rst_n = 1'b0;
    vld   = '0;
    dat   = '0;

    // Reset state
    #2;
    check_eq("rst_req",   {31'b0, req_w[0]},  32'd0);
    check_eq("rst_level", {29'b0, lvl_w[0]},  32'd0);
    check_eq("rst_busy",  {31'b0, busy_w[0]}, 32'd0);
    check_eq("rst_ready", {31'b0, rdy_w[0]},  32'd0);
    check_eq("rst_tmo",   {31'b0, tmo_w[0]},  32'd0);
    check_eq("rst_data",  {24'b0, ad_w[0]},   32'd0);
    tick(3);
    rst_n = 1'b1;
    tick(1);
    check_eq("ready_after_rst", {31'b0, rdy_w[0]}, 32'd1);

    // 4-phase single word, ack 3 samples after each req change
    ack_en[0] = 1'b1;
    push(0, 8'hA5);
    check_eq("t1_level",      {29'b0, lvl_w[0]}, 32'd1);
    check_eq("t1_req_lo0",    {31'b0, req_w[0]}, 32'd0);
    tick(1);
    check_eq("t1_setup_data", {24'b0, ad_w[0]},  32'hA5);
    check_eq("t1_req_lo1",    {31'b0, req_w[0]}, 32'd0);
    check_eq("t1_level_pop",  {29'b0, lvl_w[0]}, 32'd0);
    tick(1);
    check_eq("t1_req_rise",   {31'b0, req_w[0]}, 32'd1);
    tick(4);
    check_eq("t1_req_held",   {31'b0, req_w[0]}, 32'd1);
    check_eq("t1_data_held",  {24'b0, ad_w[0]},  32'hA5);
    tick(1);
    check_eq("t1_req_fall",   {31'b0, req_w[0]}, 32'd0);
    tick(4);
    check_eq("t1_busy_rel",   {31'b0, busy_w[0]}, 32'd1);
    tick(1);
    check_eq("t1_busy_done",  {31'b0, busy_w[0]}, 32'd0);
    check_eq("t1_tmo_clear",  {31'b0, tmo_w[0]},  32'd0);

    // Timeout: ack withheld, flag exactly 8 cycles after entering REQ
    ack_en[0] = 1'b0;
    push(0, 8'h3C);
    tick(2);
    check_eq("tmo_req_rise", {31'b0, req_w[0]}, 32'd1);
    tick(7);
    check_eq("tmo_before",   {31'b0, tmo_w[0]}, 32'd0);
    tick(1);
    check_eq("tmo_set",      {31'b0, tmo_w[0]}, 32'd1);
    ack_en[0] = 1'b1;
    wait_idle(0, 100);
    check_eq("tmo_sticky",   {31'b0, tmo_w[0]}, 32'd1);

    // FIFO full with ack held low: word 1 sits in the output register, 2..5 fill the FIFO
    ack_en[0] = 1'b0;
    log_a.delete();
    for (int i = 1; i <= 5; i++) push(0, 8'(i));
    check_eq("full_level", {29'b0, lvl_w[0]}, 32'd4);
    check_eq("full_ready", {31'b0, rdy_w[0]}, 32'd0);
    check_eq("full_head",  {24'b0, ad_w[0]},  32'd1);
    ack_en[0] = 1'b1;
    push(0, 8'd6);
    wait_idle(0, 300);
    check_eq("drain_count", log_a.size(), 32'd6);
    for (int i = 0; i < 6; i++) begin
      check_eq("drain_order", (i < log_a.size()) ? {24'b0, log_a[i]} : 32'hFFFF, 32'(i + 1));
    end

    // 2-phase streaming: one req transition per word, no return to zero
    ack_en[1] = 1'b1;
    log_b.delete();
    push(1, 8'h01);
    push(1, 8'h02);
    push(1, 8'h03);
    wait_idle(1, 200);
    exp_b = '{9'h101, 9'h002, 9'h103};
    check_eq("p2_edges", log_b.size(), 32'd3);
    for (int i = 0; i < 3; i++) begin
      check_eq("p2_edge", (i < log_b.size()) ? {23'b0, log_b[i]} : 32'hFFFF, {23'b0, exp_b[i]});
    end
    check_eq("p2_req_final", {31'b0, req_w[1]}, 32'd1);

    // SYNC_STAGE sweep: req high time is 3 + SYNC_STAGE cycles with this responder
    ack_en[2] = 1'b1;
    ack_en[3] = 1'b1;
    dat[2]    = 8'h5A;
    dat[3]    = 8'h5A;
    vld[2]    = 1'b1;
    vld[3]    = 1'b1;
    tick(1);
    vld[2]    = 1'b0;
    vld[3]    = 1'b0;
    rise = '{-1, -1};
    fall = '{-1, -1};
    for (int c = 0; c < 40; c++) begin
      tick(1);
      for (int k = 0; k < 2; k++) begin
        if (req_w[2+k] && rise[k] < 0) rise[k] = c;
        if (!req_w[2+k] && rise[k] >= 0 && fall[k] < 0) fall[k] = c;
      end
    end
    check_eq("ss1_req_time", 32'(fall[0] - rise[0]), 32'd4);
    check_eq("ss3_req_time", 32'(fall[1] - rise[1]), 32'd6);

    // Reset mid-handshake with two words queued
    ack_en[0] = 1'b0;
    push(0, 8'h11);
    push(0, 8'h22);
    push(0, 8'h33);
    check_eq("mid_req",   {31'b0, req_w[0]}, 32'd1);
    check_eq("mid_level", {29'b0, lvl_w[0]}, 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_req",   {31'b0, req_w[0]},  32'd0);
    check_eq("mid_rst_level", {29'b0, lvl_w[0]},  32'd0);
    check_eq("mid_rst_busy",  {31'b0, busy_w[0]}, 32'd0);
    check_eq("mid_rst_tmo",   {31'b0, tmo_w[0]},  32'd0);
    check_eq("mid_rst_data",  {24'b0, ad_w[0]},   32'd0);
    tick(2);
    rst_n     = 1'b1;
    ack_en[0] = 1'b1;
    log_a.delete();
    tick(20);
    check_eq("post_rst_no_word", log_a.size(), 32'd0);
    check_eq("post_rst_req",     {31'b0, req_w[0]},  32'd0);
    check_eq("post_rst_busy",    {31'b0, busy_w[0]}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
